// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus sequencer.
//   - state_t         : sequencer phase encoding
//   - *_DEF constants : default widths and strobe phase lengths
//   - bin2bcd/bcd2bin : packed-BCD conversion helpers, used only when the
//                       RTC_BUS_BCD_EN macro is defined
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP_A,
    DATA,
    GAP_D,
    FIN
  } state_t;

  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 8;
  localparam int NREG_DEF   = 9;  // seconds..year plus timer h/m/s
  localparam int T_ADDR_DEF = 4;
  localparam int T_DATA_DEF = 4;
  localparam int T_GAP_DEF  = 2;

  // Binary to packed BCD; anything above 99 saturates to 8'h99.
  function automatic logic [7:0] bin2bcd(input logic [7:0] bin);
    logic [7:0] tens;
    logic [7:0] units;
    if (bin > 8'd99) return 8'h99;
    tens  = bin / 8'd10;
    units = bin % 8'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  // Packed BCD to binary; a nibble above 9 is treated as 9.
  function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (bcd[7:4] > 4'd9) ? 4'd9 : bcd[7:4];
    units = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    return 8'(tens) * 8'd10 + 8'(units);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase-length down-counter for the bus sequencer.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   load     : reload the counter with load_val (on entry to a new phase)
//   load_val : phase length in cycles (>= 1)
//   last     : high during the final cycle of the loaded phase
module rtc_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          last
);

  logic [TW-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == TW'(1));

endmodule

// File: rtl/rtc_bus_burst_seq.sv
// Burst sequencer for the external RTC chip's multiplexed address/data bus.
// One start pulse runs up to NREG consecutive register reads or writes, each
// made of ADDR, GAP_A, DATA and GAP_D strobe phases.
//   CLK, Reset          : clock and synchronous active-high reset
//   start, cmd_wr       : command request and direction (1 = write)
//   base_addr, count    : first register address and burst length
//   wr_data / rd_data   : NREG slots of DW bits, slot i at [i*DW +: DW]
//   busy, done          : burst in progress / one-cycle completion pulse
//   CSO, ADO, RDO, WRO  : active-low chip select, address, read, write strobes
//   bus_do/bus_oe/bus_di: split view of the shared Bus_Dato_Dir pad
// Optional feature: define RTC_BUS_BCD_EN to convert write data to packed BCD
// and read data from BCD to binary (requires DW == 8).
module rtc_bus_burst_seq
  import rtc_bus_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int T_ADDR = T_ADDR_DEF,
  parameter int T_DATA = T_DATA_DEF,
  parameter int T_GAP  = T_GAP_DEF
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       start,
  input  logic                       cmd_wr,
  input  logic [AW-1:0]              base_addr,
  input  logic [$clog2(NREG+1)-1:0]  count,
  input  logic [NREG*DW-1:0]         wr_data,
  output logic [NREG*DW-1:0]         rd_data,
  output logic                       busy,
  output logic                       done,
  output logic                       CSO,
  output logic                       ADO,
  output logic                       RDO,
  output logic                       WRO,
  output logic [DW-1:0]              bus_do,
  output logic                       bus_oe,
  input  logic [DW-1:0]              bus_di
);

  localparam int CW    = $clog2(NREG + 1);
  localparam int T_AD  = (T_ADDR > T_DATA) ? T_ADDR : T_DATA;
  localparam int T_MAX = (T_AD > T_GAP) ? T_AD : T_GAP;
  localparam int TW    = $clog2(T_MAX + 1);

  state_t            state, state_next;
  logic [CW-1:0]     idx, idx_next, count_q, count_clip;
  logic              cmd_wr_q;
  logic [AW-1:0]     base_q, addr_base, addr_cur;
  logic [NREG*DW-1:0] wr_q;
  logic              t_load, t_last;
  logic [TW-1:0]     t_val;
  logic [DW-1:0]     wr_slot, wr_conv, rd_conv;
  logic              capture;
  logic              cso_d, ado_d, rdo_d, wro_d, oe_d, busy_d, done_d;
  logic [DW-1:0]     do_d;

  rtc_phase_timer #(.TW(TW)) u_timer (
    .clk      (CLK),
    .rst      (Reset),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

  assign count_clip = (count > CW'(NREG)) ? CW'(NREG) : count;

  // The first ADDR phase is driven from the edge that accepts start, before
  // base_q is loaded, so the address comes straight from the input then.
  assign addr_base = (state == IDLE) ? base_addr : base_q;
  assign addr_cur  = addr_base + AW'(idx_next);

  always_comb begin
    wr_slot = '0;
    for (int k = 0; k < NREG; k++) begin
      if (idx_next == CW'(k)) wr_slot = wr_q[k*DW +: DW];
    end
  end

`ifdef RTC_BUS_BCD_EN
  if (DW != 8) begin : g_dw_check
    $error("rtc_bus_burst_seq: RTC_BUS_BCD_EN requires DW == 8");
  end
  assign wr_conv = DW'(bin2bcd(8'(wr_slot)));
  assign rd_conv = DW'(bcd2bin(8'(bus_di)));
`else
  assign wr_conv = wr_slot;
  assign rd_conv = bus_di;
`endif

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    t_load     = 1'b0;
    t_val      = '0;
    unique case (state)
      IDLE: if (start) begin
        idx_next = '0;
        if (count_clip == '0) begin
          state_next = FIN;
        end else begin
          state_next = ADDR;
          t_load     = 1'b1;
          t_val      = TW'(T_ADDR);
        end
      end
      ADDR: if (t_last) begin
        state_next = GAP_A;
        t_load     = 1'b1;
        t_val      = TW'(T_GAP);
      end
      GAP_A: if (t_last) begin
        state_next = DATA;
        t_load     = 1'b1;
        t_val      = TW'(T_DATA);
      end
      DATA: if (t_last) begin
        state_next = GAP_D;
        t_load     = 1'b1;
        t_val      = TW'(T_GAP);
      end
      GAP_D: if (t_last) begin
        idx_next = idx + 1'b1;
        if (idx + 1'b1 == count_q) begin
          state_next = FIN;
        end else begin
          state_next = ADDR;
          t_load     = 1'b1;
          t_val      = TW'(T_ADDR);
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin values are decoded from the upcoming state and registered, so the
  // strobes and bus lines change exactly on the phase boundaries.
  always_comb begin
    cso_d  = 1'b1;
    ado_d  = 1'b1;
    rdo_d  = 1'b1;
    wro_d  = 1'b1;
    oe_d   = 1'b0;
    do_d   = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_next)
      ADDR: begin
        cso_d  = 1'b0;
        ado_d  = 1'b0;
        wro_d  = 1'b0;
        oe_d   = 1'b1;
        do_d   = DW'(addr_cur);
        busy_d = 1'b1;
      end
      GAP_A, GAP_D: busy_d = 1'b1;
      DATA: begin
        cso_d  = 1'b0;
        busy_d = 1'b1;
        if (cmd_wr_q) begin
          wro_d = 1'b0;
          oe_d  = 1'b1;
          do_d  = wr_conv;
        end else begin
          rdo_d = 1'b0;
        end
      end
      FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      count_q  <= '0;
      cmd_wr_q <= 1'b0;
      base_q   <= '0;
      wr_q     <= '0;
      CSO      <= 1'b1;
      ADO      <= 1'b1;
      RDO      <= 1'b1;
      WRO      <= 1'b1;
      bus_oe   <= 1'b0;
      bus_do   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      CSO    <= cso_d;
      ADO    <= ado_d;
      RDO    <= rdo_d;
      WRO    <= wro_d;
      bus_oe <= oe_d;
      bus_do <= do_d;
      busy   <= busy_d;
      done   <= done_d;
      if (state == IDLE && start) begin
        cmd_wr_q <= cmd_wr;
        base_q   <= base_addr;
        count_q  <= count_clip;
        wr_q     <= wr_data;
      end
    end
  end

  // Read data is sampled on the final DATA cycle, when the chip's output has
  // had the whole strobe to settle.
  assign capture = (state == DATA) && t_last && !cmd_wr_q;

  // NOTE: the read-result slots are reset like ordinary registers because the
  // host may read rd_data before any burst has filled it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_data <= '0;
    end else if (capture) begin
      for (int k = 0; k < NREG; k++) begin
        if (idx == CW'(k)) rd_data[k*DW +: DW] <= rd_conv;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_burst_seq.sv
// Scoreboard bench for rtc_bus_burst_seq: stimulus pushes the expected bus
// phases and completion into a queue, and a monitor on the falling clock edge
// pops and compares whenever the DUT opens a phase or pulses done.
module tb_rtc_bus_burst_seq;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int NREG  = 9;
  localparam int P_LEN = 12;  // 4 + 4 + 2*2 cycles per register

  localparam int EXP_ADDR  = 0;
  localparam int EXP_WDATA = 1;
  localparam int EXP_RDATA = 2;
  localparam int EXP_DONE  = 3;

  typedef struct {
    int                 kind;
    logic [7:0]         val;
    logic [NREG*DW-1:0] rd;
    int                 cyc;
  } exp_t;

  logic               CLK = 1'b0;
  logic               Reset = 1'b1;
  logic               start = 1'b0;
  logic               cmd_wr = 1'b0;
  logic [AW-1:0]      base_addr = '0;
  logic [3:0]         count = '0;
  logic [NREG*DW-1:0] wr_data = '0;
  logic [NREG*DW-1:0] rd_data;
  logic               busy, done, CSO, ADO, RDO, WRO, bus_oe;
  logic [DW-1:0]      bus_do, bus_di;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  logic [7:0]         rd_mem [0:255];
  logic [7:0]         cur_addr = '0;
  logic [NREG*DW-1:0] exp_rd = '0;
  logic               prev_ado = 1'b1;
  logic               prev_cso = 1'b1;

  rtc_bus_burst_seq #(
    .DW(DW), .AW(AW), .NREG(NREG), .T_ADDR(4), .T_DATA(4), .T_GAP(2)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (start),
    .cmd_wr    (cmd_wr),
    .base_addr (base_addr),
    .count     (count),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .CSO       (CSO),
    .ADO       (ADO),
    .RDO       (RDO),
    .WRO       (WRO),
    .bus_do    (bus_do),
    .bus_oe    (bus_oe),
    .bus_di    (bus_di)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RTC chip model: returns the stored byte for the most recent address phase.
  assign bus_di = rd_mem[cur_addr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] exp_w(input logic [7:0] v);
`ifdef RTC_BUS_BCD_EN
    if (v > 8'd99) return 8'h99;
    return {4'(v / 8'd10), 4'(v % 8'd10)};
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] exp_r(input logic [7:0] v);
`ifdef RTC_BUS_BCD_EN
    logic [7:0] t, u;
    t = (v[7:4] > 4'd9) ? 8'd9 : 8'(v[7:4]);
    u = (v[3:0] > 4'd9) ? 8'd9 : 8'(v[3:0]);
    return t * 8'd10 + u;
`else
    return v;
`endif
  endfunction

  task automatic push(input int kind, input logic [7:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.rd   = exp_rd;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Queue the expected phases, then pulse start for one cycle. Returns during
  // cycle 1 of the burst (the first ADDR cycle).
  task automatic issue_burst(input bit wr, input logic [7:0] base, input int cnt,
                             input logic [NREG*DW-1:0] wd);
    int n;
    int t0;
    logic [7:0] a;
    n = (cnt > NREG) ? NREG : cnt;
    @(posedge CLK);
    #1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      push(EXP_ADDR, a, 0);
      if (wr) begin
        push(EXP_WDATA, exp_w(wd[i*DW +: DW]), 0);
      end else begin
        exp_rd[i*DW +: DW] = exp_r(rd_mem[a]);
        push(EXP_RDATA, 8'h00, 0);
      end
    end
    push(EXP_DONE, 8'h00, t0 + 1 + n * P_LEN);
    start     = 1'b1;
    cmd_wr    = wr;
    base_addr = base;
    count     = 4'(cnt);
    wr_data   = wd;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail(name);
      sb.delete();
    end
  endtask

  // Monitor: compares every phase opening and every done pulse against the queue.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (!RDO) check("rdo_low_with_oe", bus_oe, 1'b0);
      if (!ADO && prev_ado) begin
        if (sb.size() == 0) begin
          fail("unexpected_addr_phase");
        end else begin
          mon_e = sb.pop_front();
          check("addr_phase_kind", mon_e.kind, EXP_ADDR);
          check("addr_value", bus_do, mon_e.val);
          check("addr_oe", bus_oe, 1'b1);
          cur_addr = bus_do;
        end
      end
      if (!CSO && ADO && prev_cso) begin
        if (sb.size() == 0) begin
          fail("unexpected_data_phase");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind == EXP_WDATA) begin
            check("wdata_wro", WRO, 1'b0);
            check("wdata_oe", bus_oe, 1'b1);
            check("wdata_value", bus_do, mon_e.val);
          end else begin
            check("rdata_phase_kind", mon_e.kind, EXP_RDATA);
            check("rdata_rdo", RDO, 1'b0);
          end
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          mon_e = sb.pop_front();
          check("done_kind", mon_e.kind, EXP_DONE);
          check("done_cycle", cyc, mon_e.cyc);
          check("done_busy_low", busy, 1'b0);
          check("done_rd_data", rd_data, mon_e.rd);
        end
      end
    end
    prev_ado = ADO;
    prev_cso = CSO;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREG*DW-1:0] wd;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
    rd_mem[8'h10] = 8'h31;
    rd_mem[8'h11] = 8'h52;
    rd_mem[8'h12] = 8'h73;
    rd_mem[8'h30] = 8'h45;
    rd_mem[8'h31] = 8'h12;
    rd_mem[8'h60] = 8'h23;

    // Reset values.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cso", CSO, 1'b1);
    check("rst_ado", ADO, 1'b1);
    check("rst_rdo", RDO, 1'b1);
    check("rst_wro", WRO, 1'b1);
    check("rst_oe", bus_oe, 1'b0);
    check("rst_do", bus_do, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 72'h0);
    Reset = 1'b0;
    repeat (2) @(posedge CLK);

    // Write burst: 0x21..0x23 with 0x00/0x0A/0x08, done at cycle 37.
    issue_burst(1'b1, 8'h21, 3, 72'h08_0A_00);
    check("wr_busy_cycle1", busy, 1'b1);
    wait_drain("drain_write3");

    // Read burst of 3, then of 2: slot 2 must keep its earlier value.
    issue_burst(1'b0, 8'h10, 3, '0);
    wait_drain("drain_read3");
    issue_burst(1'b0, 8'h30, 2, '0);
    wait_drain("drain_read2");
`ifndef RTC_BUS_BCD_EN
    check("rd_slot0_hand", rd_data[7:0], 8'h45);
    check("rd_slot1_hand", rd_data[15:8], 8'h12);
    check("rd_slot2_kept", rd_data[23:16], 8'h73);
`endif

    // count = 0: done at cycle 1, no bus activity, busy never rises.
    issue_burst(1'b1, 8'h00, 0, '0);
    check("cnt0_cso", CSO, 1'b1);
    check("cnt0_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("cnt0_cso_after", CSO, 1'b1);
      check("cnt0_busy_after", busy, 1'b0);
    end
    wait_drain("drain_cnt0");

    // Address wrap 0xFF -> 0x00, with a start pulse while busy that must be ignored.
    issue_burst(1'b1, 8'hFF, 2, 72'h22_11);
    repeat (5) @(posedge CLK);
    #1;
    start     = 1'b1;
    cmd_wr    = 1'b0;
    base_addr = 8'h55;
    count     = 4'd1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_drain("drain_wrap");

    // count above NREG is clipped to 9 registers.
    wd = '0;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = 8'(i + 1);
    issue_burst(1'b1, 8'h00, 15, wd);
    wait_drain("drain_clip");

    // Reset during DATA of register 2 (cycle 20) of a 5-register burst.
    issue_burst(1'b1, 8'h40, 5, 72'h05_04_03_02_01);
    repeat (19) @(posedge CLK);
    #1;
    Reset = 1'b1;
    sb.delete();
    exp_rd = '0;
    @(posedge CLK);
    #1;
    check("abort_cso", CSO, 1'b1);
    check("abort_ado", ADO, 1'b1);
    check("abort_rdo", RDO, 1'b1);
    check("abort_wro", WRO, 1'b1);
    check("abort_oe", bus_oe, 1'b0);
    check("abort_done", done, 1'b0);
    Reset = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("abort_busy", busy, 1'b0);
    issue_burst(1'b1, 8'h07, 1, 72'h33);
    wait_drain("drain_after_abort");

`ifdef RTC_BUS_BCD_EN
    // BCD conversion: 59 -> 0x59, 150 -> 0x99, read 0x23 -> 23.
    issue_burst(1'b1, 8'h50, 2, {8'd150, 8'd59});
    wait_drain("drain_bcd_wr");
    issue_burst(1'b0, 8'h60, 1, '0);
    wait_drain("drain_bcd_rd");
    check("bcd_rd_hand", rd_data[7:0], 8'h17);
`endif

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_burst_seq.md
# rtc_bus_burst_seq

Parametrised multiplexed address/data bus sequencer for the external RTC chip. It replaces the fixed single-register read/write driver inside the top-level RTC controller. One start pulse executes a burst of up to NREG register accesses at consecutive addresses, either read or write, with programmable strobe phase lengths. The top level owns the tristate pad for Bus_Dato_Dir; this block drives and samples it through separate out, in and output-enable ports.

## Interface
Parameters:
- DW, 8, bus and register data width.
- AW, 8, register address width; addresses are driven on the low AW bits of the bus and zero-extended to DW.
- NREG, 9, maximum burst length (seconds..year plus timer h/m/s).
- T_ADDR, 4, address-phase strobe length in CLK cycles (≥1).
- T_DATA, 4, data-phase strobe length in CLK cycles (≥1).
- T_GAP, 2, all-strobes-high recovery length after each phase (≥1).

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command request; sampled only when busy=0.
- cmd_wr  in  1  1=write burst, 0=read burst; sampled with start.
- base_addr  in  AW  first register address; sampled with start.
- count  in  clog2(NREG+1)  burst length; sampled with start.
- wr_data  in  NREG*DW  write payload; slot i holds bits [i*DW +: DW]; sampled with start.
- rd_data  out  NREG*DW  read results, same slot layout.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- CSO, ADO, RDO, WRO  out  1 each  active-low chip select, address strobe, read and write strobes.
- bus_do  out  DW  value driven onto Bus_Dato_Dir.
- bus_oe  out  1  high while the block drives the bus.
- bus_di  in  DW  value sampled from Bus_Dato_Dir.

## Operation
- States: IDLE, ADDR, GAP_A, DATA, GAP_D, FIN.
- IDLE: start=1 latches cmd_wr, base_addr, count and wr_data, clears index i to 0, and moves to ADDR. If count=0, the block goes to FIN instead, with no bus activity. A count above NREG is clipped to NREG.
- ADDR (T_ADDR cycles): CSO=0, ADO=0, WRO=0, bus_oe=1, bus_do=base_addr+i. The address wraps modulo 2^AW.
- GAP_A (T_GAP cycles): CSO=1, ADO=1, RDO=1, WRO=1 and bus_oe=0.
- DATA (T_DATA cycles): CSO=0 and ADO=1.
  - Write: WRO=0, bus_oe=1, bus_do=slot i of the latched wr_data.
  - Read: RDO=0, bus_oe=0. bus_di is captured into rd_data slot i on the last DATA cycle only.
- GAP_D (T_GAP cycles): all strobes are high and bus_oe=0. Then i increments. If i reaches the latched count the state goes to FIN, otherwise back to ADDR.
- FIN (1 cycle): done=1 and busy=0, then the state returns to IDLE.
- start is ignored while busy=1 or in FIN.
- rd_data slots not accessed by the current burst keep their previous value. A write burst never modifies rd_data.
- bus_oe is never high in any cycle where RDO=0.
- Reset values: state IDLE; CSO, ADO, RDO, WRO = 1; bus_oe=0; bus_do=0; busy=0; done=0; rd_data=0.

## Timing
- start is sampled at edge 0. The first ADDR cycle is cycle 1, and busy is high from cycle 1.
- Each register takes P = T_ADDR + T_DATA + 2*T_GAP cycles.
- done is high in cycle count*P+1, and busy is low in that same cycle. A new start is accepted one cycle after done.
- Reset asserted mid-burst aborts the burst. All strobes are high and bus_oe=0 in the cycle after the reset edge, and done is not pulsed.
- Strobe outputs are registered, so there are no combinational paths from inputs to bus pins.

## Configuration
- RTC_BUS_BCD_EN defined:
  - Write slots are converted from binary to packed BCD before driving. Values above 99 saturate to 8'h99.
  - Read values are converted from BCD to binary (tens*10+units) before being stored. A nibble above 9 is treated as 9.
  - DW must be 8; elaboration fails via $error otherwise.
- RTC_BUS_BCD_EN undefined: data passes through unchanged.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enum;
  - the default phase-length constants;
  - the bin2bcd and bcd2bin functions, used only under RTC_BUS_BCD_EN.
- Sub-module rtc_phase_timer: a down-counter loaded with a phase length, asserting a last-cycle flag. It is instantiated once and reloaded on each state entry.

## Test plan
- Defaults, write burst with base_addr=0x21, count=3, slots 0x00/0x0A/0x08, macro off: bus_do=0x21,0x22,0x23 in ADDR phases and 0x00,0x0A,0x08 in DATA phases with WRO=0. done is high at cycle 37.
- Read burst with count=2 and a bench model returning 0x45 then 0x12: rd_data slots 0 and 1 become 0x45 and 0x12; the other slots are unchanged; RDO=0 never overlaps bus_oe=1.
- Macro on: writing binary 59 drives 0x59; reading 0x23 stores 23 (0x17); writing 150 drives 0x99.
- count=0: done is pulsed at cycle 1, CSO stays high throughout, and busy never rises.
- Reset asserted in the middle of DATA of register 2 of a 5-register burst: all strobes are high the next cycle, no done pulse, and a fresh start then completes normally.
- base_addr=0xFF with count=2 wraps the second address to 0x00. A start pulsed while busy has no effect.
